mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Shares one external memory bus between the core's instruction-fetch port and its data (load/store) port. It sits between `Core` and the RAM/bus slave and serialises one transaction at a time. It gives the data port priority, performs 32-bit instruction lane selection, and returns per-port stall signals with the same level semantics the pipeline already consumes. A watchdog aborts transactions whose slave never acknowledges.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum wait cycles for `bus_ready` before a transaction is aborted; range 1..1023.

Ports:
- `clk`  in  1  clock.
- `rstn`  in  1  reset, synchronous, active-low.
- `if_request`  in  1  fetch request; level, held until `if_stall` falls.
- `if_addr`  in  64  fetch address, 4-byte aligned.
- `if_stall`  out  1  high while a fetch request is outstanding.
- `if_inst`  out  32  fetched instruction; valid in the cycle `if_stall` is low and `if_request` is high.
- `mem_re`  in  1  load request; level.
- `mem_we`  in  1  store request; level; never asserted together with `mem_re`.
- `mem_addr`  in  64  data address.
- `mem_wdata`  in  64  store data.
- `mem_wmask`  in  8  store byte enables.
- `mem_stall`  out  1  high while a data request is outstanding.
- `mem_rdata`  out  64  load data; valid in the cycle `mem_stall` is low.
- `bus_en`  out  1  one-cycle transaction start strobe.
- `bus_we`  out  1  write transaction.
- `bus_addr`  out  64  transaction address.
- `bus_wdata`  out  64  write data.
- `bus_wmask`  out  8  byte enables; 0 for reads.
- `bus_rdata`  in  64  slave read data; sampled when `bus_ready` is high.
- `bus_ready`  in  1  slave completion pulse.
- `bus_timeout`  out  1  one-cycle pulse when the watchdog aborts a transaction.

## Operation
- FSM states:
  - IDLE: arbitrate.
    - `mem_re|mem_we` wins; otherwise `if_request`.
    - Record the owner (IF/MEM).
    - Register address, we, wdata and wmask into the `bus_*` registers.
    - Go to ISSUE.
    - No request: stay in IDLE.
  - ISSUE: `bus_en`=1 for exactly this cycle.
    - Clear the watchdog counter.
    - Go to WAIT.
    - `bus_ready` is already sampled in this cycle; if it is high, go to RESP.
  - WAIT: increment the counter each cycle.
    - `bus_ready` high: latch data, go to RESP.
    - Counter reaches `TIMEOUT` without `bus_ready`: pulse `bus_timeout`, latch data = 0, go to RESP.
  - RESP: the owner's stall is low for this single cycle. Go to IDLE.
- `bus_addr`, `bus_we`, `bus_wdata` and `bus_wmask` stay stable from ISSUE through RESP. They change only on an IDLE grant.
- Fetch transactions force `bus_we`=0 and `bus_wmask`=8'h00. `bus_addr` is `if_addr` with bits [2:0] cleared.
- Lane select: `if_inst` = `if_addr[2] ? rdata_q[63:32] : rdata_q[31:0]`, using the `if_addr[2]` captured at grant.
- `mem_rdata` = `rdata_q`, the full 64 bits, unshifted. Store transactions also latch `bus_rdata`; the value is don't-care.
- Stalls are combinational:
  - `if_stall` = `if_request` & !(state==RESP & owner==IF).
  - `mem_stall` = (`mem_re|mem_we`) & !(state==RESP & owner==MEM).
- No preemption. A data request arriving during a fetch waits for that fetch's RESP, then the IDLE cycle.
- A request still high in the IDLE cycle after RESP is treated as a new transaction.
- A requester dropping its request mid-transaction does not abort the transaction. It completes and its result is discarded.
- `bus_ready` in IDLE or RESP is ignored.
- Reset mid-transaction:
  - State goes to IDLE; the counter clears.
  - `bus_en`=0 in the following cycle.
  - Any late `bus_ready` is ignored.

## Timing
- Reset values:
  - state IDLE, owner IF, counter 0, `rdata_q` 0.
  - `bus_en`, `bus_we`, `bus_timeout` = 0.
  - `bus_addr`, `bus_wdata` = 0; `bus_wmask` = 0.
  - `if_inst` = 0, `mem_rdata` = 0.
  - Stalls follow their request inputs.
- Minimum latency: request seen in cycle 0 (IDLE) → `bus_en` in cycle 1 → with `bus_ready` in cycle 1, the stall is low in cycle 2. Three cycles per transaction minimum, plus one IDLE cycle between back-to-back transactions.
- `bus_ready` first seen in WAIT cycle k → RESP in cycle k+1.
- Timeout: `bus_timeout` pulses in the WAIT cycle where counter==`TIMEOUT`. RESP follows in the next cycle.
- Simultaneous IF and MEM requests in IDLE: MEM is granted. IF is granted at the earliest in the cycle after MEM's RESP, i.e. the next IDLE cycle.

## Test plan
- Single fetch:
  - Stimulus: `if_addr`=0x1004; slave returns `bus_rdata`=0xAAAA_BBBB_CCCC_DDDD with `bus_ready` in cycle 1.
  - Response: `bus_en` high only in cycle 1; `bus_addr`=0x1000; `if_stall` low in cycle 2; `if_inst`=0xAAAABBBB.
- Store with slow slave:
  - Stimulus: `mem_we`=1, addr 0x80, `mem_wmask`=0x0F, `bus_ready` 5 cycles after ISSUE.
  - Response: `bus_we`=1 and `bus_wmask`=0x0F held stable throughout; `mem_stall` low for exactly one cycle, 6 cycles after ISSUE.
- Contention:
  - Stimulus: `if_request` and `mem_re` rise in the same cycle.
  - Response: the load is issued first; the fetch's `bus_en` follows its RESP+1 cycle; `if_stall` stays high throughout.
- Timeout:
  - Stimulus: `TIMEOUT`=4, `bus_ready` never asserted on a load.
  - Response: `bus_timeout` pulses once; `mem_rdata`=0; `mem_stall` low in the next cycle; FSM returns to IDLE.
- Reset during WAIT:
  - Stimulus: `rstn`=0 for 1 cycle in WAIT, then `bus_ready` arrives.
  - Response: the `bus_ready` is ignored; all outputs are at reset values; a new request proceeds normally.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Serialises instruction-fetch and data requests onto one external memory bus.
// The data port has priority; a watchdog aborts transactions the slave never acknowledges.
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        if_request,
    input  logic [63:0] if_addr,
    output logic        if_stall,
    output logic [31:0] if_inst,
    input  logic        mem_re,
    input  logic        mem_we,
    input  logic [63:0] mem_addr,
    input  logic [63:0] mem_wdata,
    input  logic [7:0]  mem_wmask,
    output logic        mem_stall,
    output logic [63:0] mem_rdata,
    output logic        bus_en,
    output logic        bus_we,
    output logic [63:0] bus_addr,
    output logic [63:0] bus_wdata,
    output logic [7:0]  bus_wmask,
    input  logic [63:0] bus_rdata,
    input  logic        bus_ready,
    output logic        bus_timeout
);

    localparam int unsigned CNT_W = 10;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_MEM = 1'b1;

    logic [1:0]       state_q,  state_d;
    logic             owner_q,  owner_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [63:0]      rdata_q,  rdata_d;
    logic             lane_q,   lane_d;
    logic             bus_en_q, bus_en_d;
    logic             we_q,     we_d;
    logic [63:0]      addr_q,   addr_d;
    logic [63:0]      wdata_q,  wdata_d;
    logic [7:0]       wmask_q,  wmask_d;
    logic             timeout_c;

    // Fetches are always 4-byte aligned; only bit 2 selects the lane.
    logic unused_addr_bits;
    assign unused_addr_bits = ^if_addr[1:0];

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            owner_q  <= OWN_IF;
            cnt_q    <= '0;
            rdata_q  <= '0;
            lane_q   <= 1'b0;
            bus_en_q <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wmask_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            lane_q   <= lane_d;
            bus_en_q <= bus_en_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wmask_q  <= wmask_d;
        end
    end

    // Arbitration, issue, wait/watchdog and response sequencing.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        lane_d    = lane_q;
        bus_en_d  = 1'b0;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wmask_d   = wmask_q;
        timeout_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (mem_re || mem_we) begin
                    owner_d  = OWN_MEM;
                    addr_d   = mem_addr;
                    we_d     = mem_we;
                    wdata_d  = mem_wdata;
                    wmask_d  = mem_we ? mem_wmask : 8'h00;
                    bus_en_d = 1'b1;
                    state_d  = S_ISSUE;
                end else if (if_request) begin
                    owner_d  = OWN_IF;
                    addr_d   = {if_addr[63:3], 3'b000};
                    we_d     = 1'b0;
                    wdata_d  = '0;
                    wmask_d  = 8'h00;
                    lane_d   = if_addr[2];
                    bus_en_d = 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d = '0;
                if (bus_ready) begin
                    rdata_d = bus_rdata;
                    state_d = S_RESP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A completion in the final watchdog cycle still wins over the abort.
                if (bus_ready) begin
                    rdata_d = bus_rdata;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    timeout_c = 1'b1;
                    rdata_d   = '0;
                    state_d   = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign if_stall    = if_request & ~((state_q == S_RESP) & (owner_q == OWN_IF));
    assign mem_stall   = (mem_re | mem_we) & ~((state_q == S_RESP) & (owner_q == OWN_MEM));
    assign if_inst     = lane_q ? rdata_q[63:32] : rdata_q[31:0];
    assign mem_rdata   = rdata_q;
    assign bus_en      = bus_en_q;
    assign bus_we      = we_q;
    assign bus_addr    = addr_q;
    assign bus_wdata   = wdata_q;
    assign bus_wmask   = wmask_q;
    assign bus_timeout = timeout_c;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (TIMEOUT = 4).
// Inputs change 2 time units after each rising edge; outputs are sampled 1 unit later.
module tb_mem_bus_arbiter;

    logic        clk;
    logic        rstn;
    logic        if_request;
    logic [63:0] if_addr;
    logic        if_stall;
    logic [31:0] if_inst;
    logic        mem_re;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_stall;
    logic [63:0] mem_rdata;
    logic        bus_en;
    logic        bus_we;
    logic [63:0] bus_addr;
    logic [63:0] bus_wdata;
    logic [7:0]  bus_wmask;
    logic [63:0] bus_rdata;
    logic        bus_ready;
    logic        bus_timeout;

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .if_request (if_request),
        .if_addr    (if_addr),
        .if_stall   (if_stall),
        .if_inst    (if_inst),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask),
        .mem_stall  (mem_stall),
        .mem_rdata  (mem_rdata),
        .bus_en     (bus_en),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_wmask  (bus_wmask),
        .bus_rdata  (bus_rdata),
        .bus_ready  (bus_ready),
        .bus_timeout(bus_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset;
        rstn = 1'b0; if_request = 1'b0; if_addr = '0; mem_re = 1'b0; mem_we = 1'b0;
        mem_addr = '0; mem_wdata = '0; mem_wmask = '0; bus_rdata = '0; bus_ready = 1'b0;
        tick; tick;
        #1;
        checks++; if (bus_en !== 1'b0) begin errors++; $display("FAIL reset_bus_en: got %b want 0", bus_en); end
        checks++; if (bus_we !== 1'b0) begin errors++; $display("FAIL reset_bus_we: got %b want 0", bus_we); end
        checks++; if (bus_addr !== 64'h0) begin errors++; $display("FAIL reset_bus_addr: got %h want 0", bus_addr); end
        checks++; if (bus_wdata !== 64'h0) begin errors++; $display("FAIL reset_bus_wdata: got %h want 0", bus_wdata); end
        checks++; if (bus_wmask !== 8'h00) begin errors++; $display("FAIL reset_bus_wmask: got %h want 0", bus_wmask); end
        checks++; if (bus_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", bus_timeout); end
        checks++; if (if_inst !== 32'h0) begin errors++; $display("FAIL reset_if_inst: got %h want 0", if_inst); end
        checks++; if (mem_rdata !== 64'h0) begin errors++; $display("FAIL reset_mem_rdata: got %h want 0", mem_rdata); end
        checks++; if (if_stall !== 1'b0 || mem_stall !== 1'b0) begin errors++; $display("FAIL reset_stalls_idle: got %b%b want 00", if_stall, mem_stall); end
        // Stalls follow the request levels even while held in reset.
        if_request = 1'b1; mem_re = 1'b1;
        #1;
        checks++; if (if_stall !== 1'b1 || mem_stall !== 1'b1) begin errors++; $display("FAIL reset_stalls_follow: got %b%b want 11", if_stall, mem_stall); end
        tick;
        checks++; if (bus_en !== 1'b0) begin errors++; $display("FAIL reset_no_grant: got %b want 0", bus_en); end
        if_request = 1'b0; mem_re = 1'b0;
        rstn = 1'b1;
        tick;
    endtask

    task automatic test_single_fetch;
        if_request = 1'b1; if_addr = 64'h1004;
        #1;
        checks++; if (bus_en !== 1'b0 || if_stall !== 1'b1) begin errors++; $display("FAIL fetch_c0: got en=%b stall=%b want en=0 stall=1", bus_en, if_stall); end
        tick;
        bus_ready = 1'b1; bus_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
        #1;
        checks++; if (bus_en !== 1'b1) begin errors++; $display("FAIL fetch_c1_en: got %b want 1", bus_en); end
        checks++; if (bus_addr !== 64'h1000) begin errors++; $display("FAIL fetch_addr: got %h want 1000", bus_addr); end
        checks++; if (bus_we !== 1'b0 || bus_wmask !== 8'h00) begin errors++; $display("FAIL fetch_we_mask: got we=%b mask=%h want 0/00", bus_we, bus_wmask); end
        checks++; if (if_stall !== 1'b1) begin errors++; $display("FAIL fetch_c1_stall: got %b want 1", if_stall); end
        tick;
        bus_ready = 1'b0;
        #1;
        checks++; if (bus_en !== 1'b0) begin errors++; $display("FAIL fetch_c2_en: got %b want 0", bus_en); end
        checks++; if (if_stall !== 1'b0) begin errors++; $display("FAIL fetch_c2_stall: got %b want 0", if_stall); end
        checks++; if (if_inst !== 32'hAAAABBBB) begin errors++; $display("FAIL fetch_inst_hi: got %h want aaaabbbb", if_inst); end
        if_request = 1'b0;
        tick;
        #1;
        checks++; if (bus_en !== 1'b0 || if_stall !== 1'b0) begin errors++; $display("FAIL fetch_idle: got en=%b stall=%b want 0/0", bus_en, if_stall); end
    endtask

    task automatic test_store_slow;
        mem_we = 1'b1; mem_addr = 64'h80; mem_wdata = 64'h1122_3344_5566_7788; mem_wmask = 8'h0F;
        tick;
        #1;
        checks++; if (bus_en !== 1'b1) begin errors++; $display("FAIL store_issue_en: got %b want 1", bus_en); end
        checks++; if (bus_we !== 1'b1 || bus_wmask !== 8'h0F) begin errors++; $display("FAIL store_issue_we_mask: got %b/%h want 1/0f", bus_we, bus_wmask); end
        checks++; if (bus_addr !== 64'h80 || bus_wdata !== 64'h1122_3344_5566_7788) begin errors++; $display("FAIL store_issue_addr_data: got %h/%h", bus_addr, bus_wdata); end
        // Ready lands 5 cycles after ISSUE, the last WAIT cycle before the watchdog would fire.
        for (int k = 1; k <= 6; k++) begin
            tick;
            bus_ready = (k == 5);
            bus_rdata = 64'h0BAD_F00D_0BAD_F00D;
            #1;
            checks++; if (bus_en !== 1'b0 || bus_we !== 1'b1 || bus_wmask !== 8'h0F || bus_addr !== 64'h80 || bus_wdata !== 64'h1122_3344_5566_7788) begin
                errors++; $display("FAIL store_hold_k%0d: got en=%b we=%b mask=%h addr=%h", k, bus_en, bus_we, bus_wmask, bus_addr);
            end
            checks++; if (bus_timeout !== 1'b0) begin errors++; $display("FAIL store_no_timeout_k%0d: got %b want 0", k, bus_timeout); end
            checks++; if (mem_stall !== (k != 6)) begin errors++; $display("FAIL store_stall_k%0d: got %b want %b", k, mem_stall, (k != 6)); end
        end
        bus_ready = 1'b0;
        mem_we = 1'b0;
        tick;
        #1;
        checks++; if (mem_stall !== 1'b0 || bus_en !== 1'b0) begin errors++; $display("FAIL store_idle: got stall=%b en=%b want 0/0", mem_stall, bus_en); end
    endtask

    task automatic test_contention;
        if_request = 1'b1; if_addr = 64'h3008; mem_re = 1'b1; mem_addr = 64'h40;
        #1;
        checks++; if (if_stall !== 1'b1 || mem_stall !== 1'b1) begin errors++; $display("FAIL cont_c0_stalls: got %b%b want 11", if_stall, mem_stall); end
        tick;
        bus_ready = 1'b1; bus_rdata = 64'h1111_2222_3333_4444;
        #1;
        checks++; if (bus_en !== 1'b1 || bus_addr !== 64'h40 || bus_we !== 1'b0) begin errors++; $display("FAIL cont_load_first: got en=%b addr=%h we=%b want 1/40/0", bus_en, bus_addr, bus_we); end
        tick;
        bus_ready = 1'b0;
        #1;
        checks++; if (mem_stall !== 1'b0 || mem_rdata !== 64'h1111_2222_3333_4444) begin errors++; $display("FAIL cont_load_resp: got stall=%b rdata=%h", mem_stall, mem_rdata); end
        checks++; if (if_stall !== 1'b1 || bus_en !== 1'b0) begin errors++; $display("FAIL cont_if_wait_resp: got stall=%b en=%b want 1/0", if_stall, bus_en); end
        mem_re = 1'b0;
        tick;
        #1;
        checks++; if (bus_en !== 1'b0 || if_stall !== 1'b1 || bus_addr !== 64'h40) begin errors++; $display("FAIL cont_idle: got en=%b stall=%b addr=%h want 0/1/40", bus_en, if_stall, bus_addr); end
        tick;
        bus_ready = 1'b1; bus_rdata = 64'h5555_6666_7777_8888;
        #1;
        checks++; if (bus_en !== 1'b1 || bus_addr !== 64'h3008 || if_stall !== 1'b1) begin errors++; $display("FAIL cont_fetch_issue: got en=%b addr=%h stall=%b", bus_en, bus_addr, if_stall); end
        tick;
        bus_ready = 1'b0;
        #1;
        checks++; if (if_stall !== 1'b0 || if_inst !== 32'h77778888) begin errors++; $display("FAIL cont_fetch_resp: got stall=%b inst=%h want 0/77778888", if_stall, if_inst); end
        if_request = 1'b0;
        tick;
    endtask

    task automatic test_timeout;
        int pulses;
        int t_cycle;
        bit done;
        pulses = 0; t_cycle = -1; done = 1'b0;
        mem_re = 1'b1; mem_addr = 64'h100;
        tick;
        #1;
        checks++; if (bus_en !== 1'b1) begin errors++; $display("FAIL to_issue: got %b want 1", bus_en); end
        // Counter is 0 in the first WAIT cycle, so the abort lands TIMEOUT+1 cycles after ISSUE.
        for (int c = 1; c <= 20 && !done; c++) begin
            tick;
            #1;
            if (t_cycle < 0) begin
                if (bus_timeout === 1'b1) begin
                    pulses++; t_cycle = c;
                    checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL to_stall_at_pulse: got %b want 1", mem_stall); end
                end
            end else begin
                checks++; if (mem_stall !== 1'b0 || mem_rdata !== 64'h0) begin errors++; $display("FAIL to_resp: got stall=%b rdata=%h want 0/0", mem_stall, mem_rdata); end
                checks++; if (bus_timeout !== 1'b0) begin errors++; $display("FAIL to_single_pulse: got %b want 0", bus_timeout); end
                done = 1'b1;
            end
        end
        checks++; if (t_cycle != 5) begin errors++; $display("FAIL to_cycle: got %0d want 5", t_cycle); end
        mem_re = 1'b0;
        tick;
        #1;
        checks++; if (bus_en !== 1'b0 || bus_timeout !== 1'b0 || mem_stall !== 1'b0) begin errors++; $display("FAIL to_idle: got en=%b to=%b stall=%b", bus_en, bus_timeout, mem_stall); end
        checks++; if (pulses != 1) begin errors++; $display("FAIL to_pulse_count: got %0d want 1", pulses); end
    endtask

    task automatic test_reset_in_wait;
        mem_re = 1'b1; mem_addr = 64'h200;
        tick;
        tick;
        tick;
        rstn = 1'b0; mem_re = 1'b0;
        tick;
        rstn = 1'b1;
        bus_ready = 1'b1; bus_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        #1;
        checks++; if (bus_en !== 1'b0 || bus_addr !== 64'h0 || mem_rdata !== 64'h0 || mem_stall !== 1'b0) begin
            errors++; $display("FAIL rst_wait_outputs: got en=%b addr=%h rdata=%h stall=%b", bus_en, bus_addr, mem_rdata, mem_stall);
        end
        tick;
        bus_ready = 1'b0;
        if_request = 1'b1; if_addr = 64'h1004;
        #1;
        checks++; if (mem_rdata !== 64'h0 || if_inst !== 32'h0 || bus_en !== 1'b0) begin errors++; $display("FAIL rst_late_ready: got rdata=%h inst=%h en=%b", mem_rdata, if_inst, bus_en); end
        tick;
        bus_ready = 1'b1; bus_rdata = 64'h9999_0000_AAAA_1111;
        #1;
        checks++; if (bus_en !== 1'b1 || bus_addr !== 64'h1000) begin errors++; $display("FAIL rst_new_issue: got en=%b addr=%h want 1/1000", bus_en, bus_addr); end
        tick;
        bus_ready = 1'b0;
        #1;
        checks++; if (if_stall !== 1'b0 || if_inst !== 32'h99990000) begin errors++; $display("FAIL rst_new_resp: got stall=%b inst=%h want 0/99990000", if_stall, if_inst); end
        if_request = 1'b0;
        tick;
    endtask

    initial begin
        test_reset;
        test_single_fetch;
        test_store_slow;
        test_contention;
        test_timeout;
        test_reset_in_wait;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
